aes_selftest_seq: RTL and testbench

- Sequential built-in self-test controller for an iterative AES core with a start/done handshake.
- Steps through the FIPS-197 Appendix C known-answer vectors for each enabled key size.
- For each vector it runs an encrypt, checks the ciphertext, then decrypts the captured ciphertext and checks for the original plaintext.
- Reports per-check sticky flags, pass/fail counters, timeout status and a final verdict; sits beside the AES core at top level.

---
 rtl/aes_selftest_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_aes_selftest_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_selftest_seq.sv
// Built-in self-test sequencer for an iterative AES core.
// Drives the core through the FIPS-197 Appendix C known-answer vectors for
// every enabled key size. Each vector is encrypted and checked, then the
// captured ciphertext is decrypted and checked against the plaintext.
// Per-check sticky flags, saturating pass/fail counters, a sticky timeout
// flag and a final verdict are reported.
module aes_selftest_seq #(
  parameter logic [2:0]  MODE_EN        = 3'b111,  // bit0=128, bit1=192, bit2=256
  parameter logic [15:0] ITERATIONS     = 16'd1,   // 0 = run until abort
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic         core_start,
  output logic [1:0]   core_mode,
  output logic         core_decrypt,
  output logic [255:0] core_key,
  output logic [127:0] core_in,
  input  logic         core_done,
  input  logic [127:0] core_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [5:0]   pass_flags,
  output logic [15:0]  pass_count,
  output logic [15:0]  fail_count,
  output logic         timeout_err
);

  // Known-answer constants. Keys are left-aligned in a 256-bit field.
  localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_FULL  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256    = 128'h8ea2b7ca516745bfeafc49904b496089;

  // First enabled mode and the pass_flags pattern a clean run must reach.
  localparam logic [1:0] LOWEST_MODE = MODE_EN[0] ? 2'd0 : (MODE_EN[1] ? 2'd1 : 2'd2);
  localparam logic [5:0] FLAG_MASK   = {{2{MODE_EN[2]}}, {2{MODE_EN[1]}}, {2{MODE_EN[0]}}};

  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENC_REQ  = 3'd1,
    ENC_WAIT = 3'd2,
    DEC_REQ  = 3'd3,
    DEC_WAIT = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              state, state_next;
  logic [1:0]          mode_idx, mode_nxt;
  logic [15:0]         iter_cnt, iter_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [127:0]        ct_reg;
  logic [2:0]          next_sel;
  logic [2:0]          e_idx, d_idx;
  logic                wait_hit;

  // Single-cycle events decoded by the next-state logic.
  logic ev_start;
  logic ev_enc_ok, ev_enc_bad, ev_enc_to;
  logic ev_dec_ok, ev_dec_bad, ev_dec_to;

  // Key for a mode index, unused low bits zero.
  function automatic logic [255:0] key_for(input logic [1:0] m);
    case (m)
      2'd0:    return {KEY_FULL[255:128], 128'h0};
      2'd1:    return {KEY_FULL[255:64], 64'h0};
      default: return KEY_FULL;
    endcase
  endfunction

  // Expected ciphertext for a mode index.
  function automatic logic [127:0] ct_for(input logic [1:0] m);
    case (m)
      2'd0:    return CT_128;
      2'd1:    return CT_192;
      default: return CT_256;
    endcase
  endfunction

  // Next enabled mode above cur; returns {wrapped, index}.
  function automatic logic [2:0] find_next(input logic [1:0] cur);
    logic [2:0] r;
    r = {1'b1, LOWEST_MODE};
    for (int k = 2; k >= 0; k--) begin
      if (MODE_EN[k] && (k > int'(cur))) r = {1'b0, 2'(k)};
    end
    return r;
  endfunction

  // Add with saturation at 16'hFFFF.
  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign e_idx    = {mode_idx, 1'b0};
  assign d_idx    = {mode_idx, 1'b1};
  assign wait_hit = (wait_cnt == WAIT_LAST);

  // Verdict: only disabled flags may be clear, and nothing may have failed.
  assign pass = done && ((pass_flags & FLAG_MASK) == FLAG_MASK) &&
                (fail_count == 16'd0) && (MODE_EN != 3'b000);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and event decode; abort overrides everything else.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    mode_nxt   = mode_idx;
    iter_nxt   = iter_cnt;
    next_sel   = 3'b000;
    ev_start   = 1'b0;
    ev_enc_ok  = 1'b0;
    ev_enc_bad = 1'b0;
    ev_enc_to  = 1'b0;
    ev_dec_ok  = 1'b0;
    ev_dec_bad = 1'b0;
    ev_dec_to  = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ev_start   = 1'b1;
            iter_nxt   = 16'd0;
            mode_nxt   = LOWEST_MODE;
            state_next = (MODE_EN == 3'b000) ? DONE : ENC_REQ;
          end
        end
        ENC_REQ: state_next = ENC_WAIT;
        ENC_WAIT: begin
          // A done arriving in the timeout cycle still counts as an answer.
          if (core_done) begin
            if (core_out == ct_for(mode_idx)) ev_enc_ok  = 1'b1;
            else                              ev_enc_bad = 1'b1;
            state_next = DEC_REQ;
          end else if (wait_hit) begin
            ev_enc_to  = 1'b1;
            state_next = NEXT;
          end
        end
        DEC_REQ: state_next = DEC_WAIT;
        DEC_WAIT: begin
          if (core_done) begin
            if (core_out == PLAINTEXT) ev_dec_ok  = 1'b1;
            else                       ev_dec_bad = 1'b1;
            state_next = NEXT;
          end else if (wait_hit) begin
            ev_dec_to  = 1'b1;
            state_next = NEXT;
          end
        end
        NEXT: begin
          next_sel = find_next(mode_idx);
          mode_nxt = next_sel[1:0];
          if (next_sel[2]) iter_nxt = iter_cnt + 16'd1;
          if (next_sel[2] && (ITERATIONS != 16'd0) && (iter_nxt == ITERATIONS))
            state_next = DONE;
          else
            state_next = ENC_REQ;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Core request interface, sequencing registers and the wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start   <= 1'b0;
      core_mode    <= 2'd0;
      core_decrypt <= 1'b0;
      core_key     <= 256'h0;
      core_in      <= 128'h0;
      ct_reg       <= 128'h0;
      mode_idx     <= 2'd0;
      iter_cnt     <= 16'd0;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      core_start <= (state_next == ENC_REQ) || (state_next == DEC_REQ);
      busy       <= (state_next != IDLE) && (state_next != DONE);
      done       <= (state_next == DONE);
      mode_idx   <= mode_nxt;
      iter_cnt   <= iter_nxt;

      // Request fields are loaded on entry to REQ and held through WAIT.
      if (state_next == ENC_REQ) begin
        core_mode    <= mode_nxt;
        core_key     <= key_for(mode_nxt);
        core_in      <= PLAINTEXT;
        core_decrypt <= 1'b0;
      end
      if (ev_enc_ok || ev_enc_bad) begin
        ct_reg       <= core_out;
        core_in      <= core_out;
        core_decrypt <= 1'b1;
      end

      if ((state == ENC_WAIT) || (state == DEC_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      else                                            wait_cnt <= '0;
    end
  end

  // Sticky flags, saturating counters and timeout status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_flags  <= 6'b0;
      pass_count  <= 16'd0;
      fail_count  <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (ev_start) begin
        pass_flags  <= FLAG_MASK;
        pass_count  <= 16'd0;
        fail_count  <= 16'd0;
        timeout_err <= 1'b0;
      end
      if (ev_enc_ok || ev_dec_ok) pass_count <= sat_add(pass_count, 2'd1);
      if (ev_enc_bad) begin
        pass_flags[e_idx] <= 1'b0;
        fail_count        <= sat_add(fail_count, 2'd1);
      end
      if (ev_dec_bad) begin
        pass_flags[d_idx] <= 1'b0;
        fail_count        <= sat_add(fail_count, 2'd1);
      end
      // An encrypt timeout also forfeits the decrypt that depends on it.
      if (ev_enc_to) begin
        pass_flags[e_idx] <= 1'b0;
        pass_flags[d_idx] <= 1'b0;
        fail_count        <= sat_add(fail_count, 2'd2);
        timeout_err       <= 1'b1;
      end
      if (ev_dec_to) begin
        pass_flags[d_idx] <= 1'b0;
        fail_count        <= sat_add(fail_count, 2'd1);
        timeout_err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Self-checking bench for aes_selftest_seq with a latency-10 AES core model
// that answers only the known-answer vectors correctly.
// u0: all modes, one iteration, 64-cycle timeout.
// u1: AES-192 only, three iterations.  u2: no modes enabled.
module tb_aes_selftest_seq;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_s [3];
  logic         abort_s [3];
  logic         core_start_s [3];
  logic [1:0]   core_mode_s [3];
  logic         core_decrypt_s [3];
  logic [255:0] core_key_s [3];
  logic [127:0] core_in_s [3];
  logic         core_done_s [3];
  logic [127:0] core_out_s [3];
  logic         busy_s [3];
  logic         done_s [3];
  logic         pass_s [3];
  logic [5:0]   flags_s [3];
  logic [15:0]  pcnt_s [3];
  logic [15:0]  fcnt_s [3];
  logic         tout_s [3];

  // Core model state and request log ({mode, decrypt} per core_start cycle).
  logic         m_done [3];
  logic [127:0] m_out [3];
  logic [127:0] m_res [3];
  int           m_cnt [3];
  logic         inj_done [3];
  int           n_starts [3];
  logic [2:0]   seq [3][128];
  logic         flip_192_enc = 1'b0;
  logic         hang_256_enc = 1'b0;

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_done
    assign core_done_s[g] = m_done[g] | inj_done[g];
    assign core_out_s[g]  = m_out[g];
  end

  aes_selftest_seq #(.MODE_EN(3'b111), .ITERATIONS(16'd1), .TIMEOUT_CYCLES(64)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .core_start(core_start_s[0]), .core_mode(core_mode_s[0]), .core_decrypt(core_decrypt_s[0]),
    .core_key(core_key_s[0]), .core_in(core_in_s[0]), .core_done(core_done_s[0]),
    .core_out(core_out_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .pass_flags(flags_s[0]), .pass_count(pcnt_s[0]), .fail_count(fcnt_s[0]),
    .timeout_err(tout_s[0]));

  aes_selftest_seq #(.MODE_EN(3'b010), .ITERATIONS(16'd3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .core_start(core_start_s[1]), .core_mode(core_mode_s[1]), .core_decrypt(core_decrypt_s[1]),
    .core_key(core_key_s[1]), .core_in(core_in_s[1]), .core_done(core_done_s[1]),
    .core_out(core_out_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .pass_flags(flags_s[1]), .pass_count(pcnt_s[1]), .fail_count(fcnt_s[1]),
    .timeout_err(tout_s[1]));

  aes_selftest_seq #(.MODE_EN(3'b000)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
    .core_start(core_start_s[2]), .core_mode(core_mode_s[2]), .core_decrypt(core_decrypt_s[2]),
    .core_key(core_key_s[2]), .core_in(core_in_s[2]), .core_done(core_done_s[2]),
    .core_out(core_out_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .pass_flags(flags_s[2]), .pass_count(pcnt_s[2]), .fail_count(fcnt_s[2]),
    .timeout_err(tout_s[2]));

  // Correct answer only for a known-answer request; anything else is garbage.
  function automatic logic [127:0] model_core(input logic [1:0] m, input logic dec,
                                              input logic [255:0] k, input logic [127:0] din);
    logic [255:0] ek;
    logic [127:0] ect;
    case (m)
      2'd0:    begin ek = K128; ect = C128; end
      2'd1:    begin ek = K192; ect = C192; end
      2'd2:    begin ek = K256; ect = C256; end
      default: begin ek = '1;   ect = '0;   end
    endcase
    if (k == ek && !dec && din == PT)  return ect;
    if (k == ek && dec && din == ect)  return PT;
    return ~din;
  endfunction

  // Behavioural AES core: done pulse about 10 cycles after each request.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_done[i] <= 1'b0;
      if (!rst_n) begin
        m_cnt[i] <= 0;
      end else if (core_start_s[i]) begin
        seq[i][n_starts[i] & 127] <= {core_mode_s[i], core_decrypt_s[i]};
        n_starts[i] <= n_starts[i] + 1;
        if (hang_256_enc && core_mode_s[i] == 2'd2 && !core_decrypt_s[i]) begin
          m_cnt[i] <= 0;
        end else begin
          m_cnt[i] <= 10;
          m_res[i] <= model_core(core_mode_s[i], core_decrypt_s[i], core_key_s[i], core_in_s[i])
                      ^ ((flip_192_enc && core_mode_s[i] == 2'd1 && !core_decrypt_s[i])
                         ? 128'h1 : 128'h0);
        end
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) begin
          m_done[i] <= 1'b1;
          m_out[i]  <= m_res[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk); start_s[i] = 1'b1;
    @(negedge clk); start_s[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int i, input string tag);
    int n = 0;
    while (!done_s[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(done_s[i]), 256'd1);
  endtask

  // Full clean run on u0: sequence, flags and counters.
  task automatic clean_run_u0(input string tag);
    int base;
    base = n_starts[0];
    pulse_start(0);
    wait_done(0, {tag, "_done"});
    check({tag, "_busy"},   256'(busy_s[0]),  256'd0);
    check({tag, "_pass"},   256'(pass_s[0]),  256'd1);
    check({tag, "_flags"},  256'(flags_s[0]), 256'h3f);
    check({tag, "_pcnt"},   256'(pcnt_s[0]),  256'd6);
    check({tag, "_fcnt"},   256'(fcnt_s[0]),  256'd0);
    check({tag, "_starts"}, 256'(n_starts[0] - base), 256'd6);
    for (int k = 0; k < 6; k++)
      check({tag, "_seq"}, 256'(seq[0][(base + k) & 127]), 256'(k));
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; inj_done[i] = 1'b0; n_starts[i] = 0;
    end
    idle_cycles(3);
    check("rst_busy_done", {busy_s[0], done_s[0], pass_s[0], tout_s[0]}, 256'd0);
    check("rst_counts",    {flags_s[0], pcnt_s[0], fcnt_s[0]}, 256'd0);
    check("rst_core_ctl",  {core_start_s[0], core_mode_s[0], core_decrypt_s[0]}, 256'd0);
    check("rst_core_key",  core_key_s[0], 256'd0);
    check("rst_core_in",   256'(core_in_s[0]), 256'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);

    // AES-192 only, three passes.
    base = n_starts[1];
    pulse_start(1);
    wait_done(1, "m192_done");
    check("m192_starts", 256'(n_starts[1] - base), 256'd6);
    for (int k = 0; k < 6; k++)
      check("m192_seq", 256'(seq[1][(base + k) & 127]), 256'({2'd1, 1'(k % 2)}));
    check("m192_flags", 256'(flags_s[1]), 256'b001100);
    check("m192_pcnt",  256'(pcnt_s[1]),  256'd6);
    check("m192_pass",  256'(pass_s[1]),  256'd1);

    // No modes enabled: straight to DONE, never a pass.
    pulse_start(2);
    idle_cycles(2);
    check("none_done",   256'(done_s[2]),   256'd1);
    check("none_busy",   256'(busy_s[2]),   256'd0);
    check("none_pass",   256'(pass_s[2]),   256'd0);
    check("none_flags",  256'(flags_s[2]),  256'd0);
    check("none_starts", 256'(n_starts[2]), 256'd0);

    // Clean run with every mode.
    clean_run_u0("s1");

    // core_done while DONE is ignored.
    @(negedge clk); inj_done[0] = 1'b1;
    @(negedge clk); inj_done[0] = 1'b0;
    idle_cycles(1);
    check("done_ign_pcnt", 256'(pcnt_s[0]), 256'd6);
    check("done_ign_done", 256'(done_s[0]), 256'd1);

    // Corrupt 192 encrypt; start from DONE also clears the counters.
    flip_192_enc = 1'b1;
    pulse_start(0);
    check("restart_clr", {busy_s[0], done_s[0], pcnt_s[0], fcnt_s[0]}, {2'b10, 32'd0});
    wait_done(0, "flip_done");
    check("flip_flags", 256'(flags_s[0]), 256'b110011);
    check("flip_fcnt",  256'(fcnt_s[0]),  256'd2);
    check("flip_pcnt",  256'(pcnt_s[0]),  256'd4);
    check("flip_pass",  256'(pass_s[0]),  256'd0);
    check("flip_tout",  256'(tout_s[0]),  256'd0);
    flip_192_enc = 1'b0;

    // 256 encrypt never answered: timeout, no 256 decrypt request.
    hang_256_enc = 1'b1;
    base = n_starts[0];
    pulse_start(0);
    wait_done(0, "hang_done");
    check("hang_tout",   256'(tout_s[0]),  256'd1);
    check("hang_flags",  256'(flags_s[0]), 256'b001111);
    check("hang_fcnt",   256'(fcnt_s[0]),  256'd2);
    check("hang_pcnt",   256'(pcnt_s[0]),  256'd4);
    check("hang_starts", 256'(n_starts[0] - base), 256'd5);
    check("hang_last",   256'(seq[0][(base + 4) & 127]), 256'd4);
    hang_256_enc = 1'b0;

    // Asynchronous reset while waiting on the first encrypt.
    pulse_start(0);
    idle_cycles(3);
    check("pre_rst_busy", 256'(busy_s[0]), 256'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_status", {busy_s[0], done_s[0], pass_s[0], tout_s[0], flags_s[0], pcnt_s[0], fcnt_s[0]}, 256'd0);
    check("arst_core",   {core_start_s[0], core_mode_s[0], core_decrypt_s[0], core_in_s[0]}, 256'd0);
    check("arst_key",    core_key_s[0], 256'd0);
    base = n_starts[0];
    idle_cycles(3);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(20);
    check("arst_no_req", 256'(n_starts[0] - base), 256'd0);
    clean_run_u0("s5");

    // Abort in DEC_WAIT of the first vector.
    pulse_start(0);
    n = 0;
    while (!core_decrypt_s[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_dec", 256'(core_decrypt_s[0]), 256'd1);
    idle_cycles(2);
    @(negedge clk); abort_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk); abort_s[0] = 1'b0; start_s[0] = 1'b0;
    check("abort_busy_done", {busy_s[0], done_s[0]}, 256'd0);
    check("abort_pcnt",  256'(pcnt_s[0]),  256'd1);
    check("abort_flags", 256'(flags_s[0]), 256'h3f);
    // Late core answer plus an injected pulse, both in IDLE.
    idle_cycles(15);
    @(negedge clk); inj_done[0] = 1'b1;
    @(negedge clk); inj_done[0] = 1'b0;
    idle_cycles(2);
    check("idle_ign_state", {busy_s[0], done_s[0], core_start_s[0]}, 256'd0);
    check("idle_ign_pcnt",  256'(pcnt_s[0]), 256'd1);
    clean_run_u0("s6");

    // start while busy is ignored.
    base = n_starts[0];
    pulse_start(0);
    idle_cycles(30);
    pulse_start(0);
    wait_done(0, "busy_start_done");
    check("busy_start_starts", 256'(n_starts[0] - base), 256'd6);
    check("busy_start_pcnt",   256'(pcnt_s[0]), 256'd6);
    check("busy_start_pass",   256'(pass_s[0]), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
